multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 46 ++++
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle for multicycle_control.
// instr_count exists only when MC_INSTR_COUNT_EN is defined.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       illegal_op;
    logic       mem_timeout;
`ifdef MC_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
        output RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource,
        output state, illegal_op, mem_timeout
`ifdef MC_INSTR_COUNT_EN
        , output instr_count
`endif
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
        input  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource,
        input  state, illegal_op, mem_timeout
`ifdef MC_INSTR_COUNT_EN
        , input instr_count
`endif
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM with memory-wait abort (WAIT_LIMIT, 0 = unlimited).
// Optional retired-instruction counter enabled by defining MC_INSTR_COUNT_EN.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        JAL    = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT   = CW'(WAIT_LIMIT);
    // With no limit the counter just saturates; it never triggers an abort.
    localparam logic [CW-1:0] CNT_MAX = (WAIT_LIMIT == 0) ? {CW{1'b1}} : LIMIT;

    state_t        state_q, state_d;
    logic [5:0]    op_q;
    logic [CW-1:0] wait_cnt;
    logic          stall_state;
    logic          illegal;
    logic          timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= bus.opcode;
            if (state_d != state_q || timeout)
                wait_cnt <= '0;
            else if (stall_state && !bus.mem_ready && wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        stall_state     = 1'b0;
        illegal         = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegDst      = 2'b00;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;

        unique case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready & ~reset;
                bus.PCWrite = bus.mem_ready & ~reset;
                stall_state = 1'b1;
                if (bus.mem_ready)
                    state_d = DECODE;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:         state_d = RTEXEC;
                    OP_LW, OP_SW:     state_d = MEMADR;
                    OP_BEQ:           state_d = BRANCH;
                    OP_JAL:           state_d = JAL;
                    OP_ADDI, OP_ANDI: state_d = IEXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                stall_state = 1'b1;
                if (bus.mem_ready)
                    state_d = MEMWB;
            end
            MEMWB: begin
                bus.MemtoReg = 2'b01;
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                stall_state  = 1'b1;
                if (bus.mem_ready)
                    state_d = FETCH;
            end
            RTEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = RTWB;
            end
            RTWB: begin
                bus.RegDst   = 2'b01;
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                state_d         = FETCH;
            end
            JAL: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                bus.RegDst   = 2'b10;
                bus.MemtoReg = 2'b10;
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
                state_d     = IWB;
            end
            IWB: begin
                bus.RegWrite = 1'b1;
                state_d      = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // A mem_ready arriving in the limit cycle wins over the abort.
        timeout = (WAIT_LIMIT != 0) && stall_state && !bus.mem_ready
                  && (wait_cnt == LIMIT) && !reset;
        if (timeout)
            state_d = FETCH;

        bus.illegal_op  = illegal & ~reset;
        bus.mem_timeout = timeout;
        bus.state       = state_q;
    end

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] instr_count_q;
    logic        retire;

    assign retire = (state_d == FETCH) && !timeout &&
                    (state_q == MEMWB || state_q == MEMWR || state_q == RTWB ||
                     state_q == IWB   || state_q == BRANCH || state_q == JAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instr_count_q <= '0;
        else if (retire)
            instr_count_q <= instr_count_q + 32'd1;
    end

    assign bus.instr_count = instr_count_q;
`endif
endmodule
